ms_core_scheduler: RTL and testbench

Time-multiplexes one shared mid/side transform core (1-cycle registered latency, clock-enabled, per-sample transform/bypass select) across NUM_CH independent stereo streams. Per-channel valid/ready inputs are granted round-robin, each channel's transform-enable is applied per sample, the core's in-flight result is tracked with a channel tag, and tagged results go out on a single valid/ready output with full backpressure. Sits between the per-channel sample sources and the downstream per-channel routing or DMA.

---
 rtl/ms_core_scheduler.sv | 101 ++++++++++
 tb/tb_ms_core_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_core_scheduler.sv
// rtl/ms_core_scheduler.sv - round-robin scheduler sharing one mid/side core across stereo channels
module ms_core_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [NUM_CH-1:0]      s_valid,
    output logic [NUM_CH-1:0]      s_ready,
    input  logic [16*NUM_CH-1:0]   s_L,
    input  logic [16*NUM_CH-1:0]   s_R,
    input  logic [NUM_CH-1:0]      ch_enable,
    output logic                   core_ce,
    output logic                   core_enable,
    output logic [15:0]            core_L,
    output logic [15:0]            core_R,
    input  logic [15:0]            core_mid,
    input  logic [15:0]            core_side,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CH_W-1:0]        m_ch,
    output logic [15:0]            m_mid,
    output logic [15:0]            m_side
);

    logic              p_valid;
    logic [CH_W-1:0]   p_ch;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   g;
    logic [CH_W-1:0]   cand;
    logic              found;
    logic              any_req;
    logic              capture;
    logic              issue;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        g     = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!found && s_valid[cand]) begin
                found = 1'b1;
                g     = cand;
            end
        end
    end

    assign any_req = |s_valid;

    // The output register can take the core result when empty or draining this ce cycle;
    // a new sample may enter the core when it is empty or its result is being captured.
    assign capture = ce & p_valid & (~m_valid | m_ready);
    assign issue   = ~rst & ce & any_req & (~p_valid | capture);

    // One-hot accept for the granted channel and core input mux
    always_comb begin
        s_ready    = '0;
        s_ready[g] = issue;
    end

    assign core_ce     = issue;
    assign core_enable = ch_enable[g];
    assign core_L      = s_L[16*g +: 16];
    assign core_R      = s_R[16*g +: 16];

    // Track which channel occupies the core register and advance the round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_ch    <= '0;
            rr_ptr  <= CH_W'(NUM_CH - 1);
        end else if (issue) begin
            p_valid <= 1'b1;
            p_ch    <= g;
            rr_ptr  <= g;
        end else if (capture) begin
            p_valid <= 1'b0;
        end
    end

    // Output register: capture the tagged core result, hold it under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_mid   <= '0;
            m_side  <= '0;
        end else if (capture) begin
            m_valid <= 1'b1;
            m_ch    <= p_ch;
            m_mid   <= core_mid;
            m_side  <= core_side;
        end else if (ce & m_valid & m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ms_core_scheduler.sv
// tb/tb_ms_core_scheduler.sv - bench for ms_core_scheduler with a scoreboard reference model
module tb_ms_core_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                  clk;
    logic                  rst;
    logic                  ce;
    logic [NUM_CH-1:0]     s_valid;
    logic [NUM_CH-1:0]     s_ready;
    logic [16*NUM_CH-1:0]  s_L;
    logic [16*NUM_CH-1:0]  s_R;
    logic [NUM_CH-1:0]     ch_enable;
    logic                  core_ce;
    logic                  core_enable;
    logic [15:0]           core_L;
    logic [15:0]           core_R;
    logic [15:0]           core_mid;
    logic [15:0]           core_side;
    logic                  m_valid;
    logic                  m_ready;
    logic [CH_W-1:0]       m_ch;
    logic [15:0]           m_mid;
    logic [15:0]           m_side;

    ms_core_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .s_valid(s_valid), .s_ready(s_ready), .s_L(s_L), .s_R(s_R),
        .ch_enable(ch_enable),
        .core_ce(core_ce), .core_enable(core_enable), .core_L(core_L), .core_R(core_R),
        .core_mid(core_mid), .core_side(core_side),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_mid(m_mid), .m_side(m_side)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared transform core: one registered stage, unreset, clock-enabled
    logic signed [16:0] c_sum, c_dif;
    assign c_sum = {core_L[15], core_L} + {core_R[15], core_R};
    assign c_dif = {core_L[15], core_L} - {core_R[15], core_R};
    always @(posedge clk) begin
        if (core_ce) begin
            core_mid  <= core_enable ? c_sum[16:1] : core_L;
            core_side <= core_enable ? c_dif[16:1] : core_R;
        end
    end

    typedef struct {
        int ch;
        int mid;
        int side;
        int edges;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    last_g = NUM_CH - 1;
    int    nxfer  = 0;
    bit    prev_hold = 0;
    int    prev_ch, prev_mid, prev_side;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int next_grant();
        for (int k = 1; k <= NUM_CH; k++)
            if (s_valid[(last_g + k) % NUM_CH]) return (last_g + k) % NUM_CH;
        return 0;
    endfunction

    // Check current cycle against the model, advance the model across the coming edge,
    // then move to the next falling edge where the caller sets new inputs.
    task automatic step();
        int eg, l, r;
        bit iss, emv;
        logic [NUM_CH-1:0] er;
        item_t it;
        #1;
        eg  = next_grant();
        emv = (sb.size() > 0) && (sb[0].edges >= 2);
        iss = !rst && ce && (|s_valid) && (sb.size() < 2 || m_ready);
        er  = '0;
        if (iss) er[eg] = 1'b1;
        chk("s_ready", int'(s_ready), int'(er));
        chk("core_ce", int'(core_ce), int'(iss));
        chk("m_valid", int'(m_valid), int'(emv));
        if (prev_hold) begin
            chk("hold_ch", int'(m_ch), prev_ch);
            chk("hold_mid", int'($signed(m_mid)), prev_mid);
            chk("hold_side", int'($signed(m_side)), prev_side);
        end
        if (iss) begin
            chk("core_enable", int'(core_enable), int'(ch_enable[eg]));
            chk("core_L", int'(core_L), int'(s_L[16*eg +: 16]));
            chk("core_R", int'(core_R), int'(s_R[16*eg +: 16]));
        end
        if (!rst) begin
            if (ce && emv && m_ready) begin
                it = sb.pop_front();
                chk("out_ch", int'(m_ch), it.ch);
                chk("out_mid", int'($signed(m_mid)), it.mid);
                chk("out_side", int'($signed(m_side)), it.side);
            end
            if (ce) foreach (sb[i]) sb[i].edges++;
            if (iss) begin
                l = $signed(s_L[16*eg +: 16]);
                r = $signed(s_R[16*eg +: 16]);
                it.ch    = eg;
                it.mid   = ch_enable[eg] ? ((l + r) >>> 1) : l;
                it.side  = ch_enable[eg] ? ((l - r) >>> 1) : r;
                it.edges = 1;
                sb.push_back(it);
                last_g = eg;
                nxfer++;
            end
        end
        prev_hold = !rst && emv && !(ce && m_ready);
        prev_ch   = int'(m_ch);
        prev_mid  = int'($signed(m_mid));
        prev_side = int'($signed(m_side));
        @(negedge clk);
    endtask

    task automatic drain();
        s_valid = '0;
        ce      = 1'b1;
        m_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) step();
        step();
    endtask

    task automatic single(input int ch, input int l, input int r, input int em, input int es);
        drain();
        s_valid     = '0;
        s_valid[ch] = 1'b1;
        s_L[16*ch +: 16] = 16'(l);
        s_R[16*ch +: 16] = 16'(r);
        step();
        s_valid = '0;
        step();
        chk("single_valid", int'(m_valid), 1);
        chk("single_ch", int'(m_ch), ch);
        chk("single_mid", int'($signed(m_mid)), em);
        chk("single_side", int'($signed(m_side)), es);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        ce        = 1'b1;
        s_valid   = '1;
        s_L       = '0;
        s_R       = '0;
        ch_enable = '1;
        m_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_core_ce", int'(core_ce), 0);
        chk("rst_m_ch", int'(m_ch), 0);
        chk("rst_m_mid", int'(m_mid), 0);
        chk("rst_m_side", int'(m_side), 0);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = '0;

        // Single transfer latency and transform arithmetic
        single(0, 1000, 200, 600, 400);

        // All channels continuously valid, no backpressure
        drain();
        for (int i = 0; i < NUM_CH; i++) begin
            s_L[16*i +: 16] = 16'(100 * i + 7);
            s_R[16*i +: 16] = 16'(-50 * i);
        end
        s_valid = '1;
        for (int i = 0; i < 12; i++) step();

        // Backpressure: only two samples may be accepted
        drain();
        s_valid = '1;
        m_ready = 1'b0;
        nxfer   = 0;
        for (int i = 0; i < 6; i++) step();
        chk("bp_transfers", nxfer, 2);
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Sparse clock enable
        for (int i = 0; i < 15; i++) begin
            ce      = (i % 3 == 0);
            m_ready = 1'(($urandom % 2));
            step();
        end

        // Per-channel bypass with extreme values
        ch_enable = 4'b0010;
        single(2, -32768, 32767, -32768, 32767);
        single(1, 32767, 32767, 32767, 0);
        single(1, -3, 0, -2, -2);

        // Reset while both core and output registers are full
        drain();
        s_valid = '1;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        #1;
        chk("arst_m_valid", int'(m_valid), 0);
        chk("arst_s_ready", int'(s_ready), 0);
        chk("arst_core_ce", int'(core_ce), 0);
        sb.delete();
        last_g    = NUM_CH - 1;
        prev_hold = 0;
        step();
        step();
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            s_valid   = NUM_CH'($urandom);
            ce        = ($urandom % 4) != 0;
            m_ready   = ($urandom % 3) != 0;
            ch_enable = NUM_CH'($urandom);
            s_L       = {$urandom, $urandom};
            s_R       = {$urandom, $urandom};
            if ($urandom % 8 == 0) s_L[15:0] = 16'h8000;
            if ($urandom % 8 == 0) s_R[15:0] = 16'h7fff;
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
